// File: rtl/cache_arbiter.sv
// rtl/cache_arbiter.sv - round-robin arbiter sharing one line-fill/write-back port between I- and D-caches
// Commands come from latched registers only; client data is routed combinationally back from memory.
module cache_arbiter #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, RELEASE} state_t;

  state_t              state_q, state_d;
  logic                last_d_q, last_d_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LINE_W-1:0]   wdata_q, wdata_d;
  logic                write_q, write_d;
  logic                d_req;
  logic                busy;

  assign d_req = d_pmem_read | d_pmem_write;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      last_d_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      write_q  <= write_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    write_d  = write_q;
    case (state_q)
      IDLE: begin
        // I wins when alone, or on a tie when D was the previous winner
        if (i_pmem_read && (!d_req || last_d_q)) begin
          state_d  = I_BUSY;
          last_d_d = 1'b0;
          addr_d   = i_pmem_address;
          wdata_d  = '0;
          write_d  = 1'b0;
        end else if (d_req) begin
          state_d  = D_BUSY;
          last_d_d = 1'b1;
          addr_d   = d_pmem_address;
          wdata_d  = d_pmem_write ? d_pmem_wdata : '0;
          write_d  = d_pmem_write;
        end
      end
      I_BUSY, D_BUSY: begin
        if (pmem_resp) state_d = RELEASE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = !rst && (state_q == I_BUSY || state_q == D_BUSY);

  assign pmem_read    = !rst && (state_q == I_BUSY || (state_q == D_BUSY && !write_q));
  assign pmem_write   = !rst && state_q == D_BUSY && write_q;
  assign pmem_address = busy ? addr_q : '0;
  assign pmem_wdata   = pmem_write ? wdata_q : '0;

  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;
  assign i_pmem_resp  = !rst && state_q == I_BUSY && pmem_resp;
  assign d_pmem_resp  = !rst && state_q == D_BUSY && pmem_resp;

endmodule
